eth_header_parser: RTL and testbench

ETH_HEADER_PARSER -- requirements
Module: eth_header_parser

---
 rtl/eth_pkg.sv | 21 ++
 rtl/eth_sat_counter.sv | 25 ++
 rtl/eth_header_parser.sv | 174 +++++++++++++++++
 tb/tb_eth_header_parser.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet header parser.
// The VLAN state exists only when ETH_VLAN_EN is defined.
package eth_pkg;

  localparam int          ETH_MAC_BYTES  = 6;
  localparam int          ETH_HDR_BYTES  = 14;
  localparam int          ETH_VLAN_BYTES = 4;
  localparam logic [15:0] ETHERTYPE_VLAN = 16'h8100;

  typedef enum logic [2:0] {
    IDLE,
    DST,
    SRC,
    TYPE,
    PAYLOAD
`ifdef ETH_VLAN_EN
    , VLAN
`endif
  } state_t;

endpackage

// File: rtl/eth_sat_counter.sv
// Event counter that either saturates at all-ones or wraps to zero,
// selected by the SATURATE parameter.
module eth_sat_counter #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic at_max;
  assign at_max = &count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !(SATURATE && at_max)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/eth_header_parser.sv
// Byte-stream Ethernet header parser: extracts DST/SRC/EtherType, forwards payload
// with one cycle of latency and flags runt frames. Define ETH_VLAN_EN for 802.1Q tag support.
module eth_header_parser
  import eth_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             in_available,
  input  logic             in_datavalid,
  input  logic [7:0]       in_data,
  output logic [47:0]      dst_mac,
  output logic [47:0]      src_mac,
  output logic [15:0]      ethertype,
  output logic             hdr_valid,
  output logic             pay_valid,
  output logic [7:0]       pay_data,
  output logic             pay_first,
  output logic             pay_last,
  output logic             runt_err,
`ifdef ETH_VLAN_EN
  output logic [11:0]      vlan_id,
`endif
  output logic [CNT_W-1:0] frame_count,
  output logic [ERR_W-1:0] runt_count
);

  // Header byte index runs 0..13 across DST/SRC/TYPE, and 0..3 again inside VLAN.
  localparam logic [3:0] IDX_DST_END  = 4'(ETH_MAC_BYTES - 1);
  localparam logic [3:0] IDX_SRC_END  = 4'(2 * ETH_MAC_BYTES - 1);
  localparam logic [3:0] IDX_HDR_END  = 4'(ETH_HDR_BYTES - 1);
  localparam logic [3:0] IDX_VLAN_END = 4'(ETH_VLAN_BYTES - 1);

  state_t     state, next_state;
  logic [3:0] idx, next_idx;
  logic       hdr_done, runt_hit, pay_take;
  logic       first_pending;
  logic       is_last;

  assign is_last = ~in_available;

`ifdef ETH_VLAN_EN
  logic vlan_tag;
  assign vlan_tag = ({ethertype[7:0], in_data} == ETHERTYPE_VLAN);
`endif

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= next_state;
      idx   <= next_idx;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    next_idx   = idx;
    hdr_done   = 1'b0;
    runt_hit   = 1'b0;
    pay_take   = 1'b0;
    if (in_datavalid) begin
      next_idx = idx + 4'd1;
      case (state)
        IDLE: next_state = DST;
        DST:  if (idx == IDX_DST_END) next_state = SRC;
        SRC:  if (idx == IDX_SRC_END) next_state = TYPE;
        TYPE: begin
          if (idx == IDX_HDR_END) begin
`ifdef ETH_VLAN_EN
            if (vlan_tag) begin
              next_state = VLAN;
              next_idx   = '0;
            end else begin
              hdr_done = 1'b1;
            end
`else
            hdr_done = 1'b1;
`endif
          end
        end
`ifdef ETH_VLAN_EN
        VLAN: if (idx == IDX_VLAN_END) hdr_done = 1'b1;
`endif
        PAYLOAD: begin
          pay_take = 1'b1;
          next_idx = idx;
          if (is_last) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
      // A frame that ends anywhere before header completion is a runt.
      if (hdr_done) begin
        next_idx   = '0;
        next_state = is_last ? IDLE : PAYLOAD;
      end else if (is_last && state != PAYLOAD) begin
        runt_hit   = 1'b1;
        next_idx   = '0;
        next_state = IDLE;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      dst_mac       <= '0;
      src_mac       <= '0;
      ethertype     <= '0;
      hdr_valid     <= 1'b0;
      pay_valid     <= 1'b0;
      pay_data      <= '0;
      pay_first     <= 1'b0;
      pay_last      <= 1'b0;
      runt_err      <= 1'b0;
      first_pending <= 1'b0;
`ifdef ETH_VLAN_EN
      vlan_id       <= '0;
`endif
    end else begin
      hdr_valid <= hdr_done;
      runt_err  <= runt_hit;
      pay_valid <= 1'b0;
      pay_first <= 1'b0;
      pay_last  <= 1'b0;
      if (in_datavalid) begin
        case (state)
          IDLE, DST: dst_mac   <= {dst_mac[39:0], in_data};
          SRC:       src_mac   <= {src_mac[39:0], in_data};
          TYPE: begin
            ethertype <= {ethertype[7:0], in_data};
`ifdef ETH_VLAN_EN
            if (hdr_done) vlan_id <= '0;
`endif
          end
`ifdef ETH_VLAN_EN
          VLAN: begin
            if (idx == 4'd0)      vlan_id   <= {in_data[3:0], vlan_id[7:0]};
            else if (idx == 4'd1) vlan_id   <= {vlan_id[11:8], in_data};
            else                  ethertype <= {ethertype[7:0], in_data};
          end
`endif
          PAYLOAD: begin
            pay_valid <= 1'b1;
            pay_data  <= in_data;
            pay_first <= first_pending;
            pay_last  <= is_last;
          end
          default: ;
        endcase
      end
      if (hdr_done)      first_pending <= 1'b1;
      else if (pay_take) first_pending <= 1'b0;
    end
  end

  eth_sat_counter #(.WIDTH(CNT_W), .SATURATE(1'b0)) u_frame_cnt (
    .clk   (CLOCK),
    .rst_n (RESET_N),
    .inc   (hdr_done),
    .count (frame_count)
  );

  eth_sat_counter #(.WIDTH(ERR_W), .SATURATE(1'b1)) u_runt_cnt (
    .clk   (CLOCK),
    .rst_n (RESET_N),
    .inc   (runt_hit),
    .count (runt_count)
  );

endmodule

// File: tb/tb_eth_header_parser.sv
// Scoreboard bench for eth_header_parser: a frame-level reference model queues expected
// header/payload/runt events with their due cycle; a monitor pops and compares them.
module tb_eth_header_parser;

  localparam int CNT_W = 4;
  localparam int ERR_W = 3;

  typedef logic [7:0] byte_q_t[$];
  typedef enum int {EV_HDR, EV_PAY, EV_RUNT} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    longint      cyc;
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] etype;
    logic [11:0] vid;
    logic [7:0]  data;
    logic        first;
    logic        last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_available;
  logic             in_datavalid;
  logic [7:0]       in_data;
  logic [47:0]      dst_mac, src_mac;
  logic [15:0]      ethertype;
  logic             hdr_valid, pay_valid, pay_first, pay_last, runt_err;
  logic [7:0]       pay_data;
  logic [CNT_W-1:0] frame_count;
  logic [ERR_W-1:0] runt_count;
`ifdef ETH_VLAN_EN
  logic [11:0]      vlan_id;
`endif

  eth_header_parser #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .CLOCK        (clk),
    .RESET_N      (rst_n),
    .in_available (in_available),
    .in_datavalid (in_datavalid),
    .in_data      (in_data),
    .dst_mac      (dst_mac),
    .src_mac      (src_mac),
    .ethertype    (ethertype),
    .hdr_valid    (hdr_valid),
    .pay_valid    (pay_valid),
    .pay_data     (pay_data),
    .pay_first    (pay_first),
    .pay_last     (pay_last),
    .runt_err     (runt_err),
`ifdef ETH_VLAN_EN
    .vlan_id      (vlan_id),
`endif
    .frame_count  (frame_count),
    .runt_count   (runt_count)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_hdr = 0, n_pay = 0, n_runt = 0;
  int   mdl_frames = 0, mdl_runts = 0;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_event(input ev_kind_e k);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got %s with empty scoreboard, expected none", k.name());
    end else begin
      e = sb.pop_front();
      check("event_kind", 64'(k), 64'(e.kind));
      check("event_cycle", 64'(cyc), 64'(e.cyc));
      case (k)
        EV_HDR: begin
          check("dst_mac", 64'(dst_mac), 64'(e.dst));
          check("src_mac", 64'(src_mac), 64'(e.src));
          check("ethertype", 64'(ethertype), 64'(e.etype));
`ifdef ETH_VLAN_EN
          check("vlan_id", 64'(vlan_id), 64'(e.vid));
`endif
        end
        EV_PAY: begin
          check("pay_data", 64'(pay_data), 64'(e.data));
          check("pay_first", 64'(pay_first), 64'(e.first));
          check("pay_last", 64'(pay_last), 64'(e.last));
        end
        default: ;
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (hdr_valid) begin n_hdr++;  check_event(EV_HDR);  end
      if (pay_valid) begin n_pay++;  check_event(EV_PAY);  end
      if (runt_err)  begin n_runt++; check_event(EV_RUNT); end
    end
  end

  function automatic byte_q_t make_frame(input logic [47:0] dst, input logic [47:0] src,
                                         input logic [15:0] et, input int len);
    byte_q_t     f;
    logic [47:0] d = dst;
    logic [47:0] s = src;
    for (int i = 0; i < 6; i++) begin f.push_back(d[47:40]); d = d << 8; end
    for (int i = 0; i < 6; i++) begin f.push_back(s[47:40]); s = s << 8; end
    f.push_back(et[15:8]);
    f.push_back(et[7:0]);
    while (f.size() > len) void'(f.pop_back());
    while (f.size() < len) f.push_back(8'($urandom_range(0, 255)));
    return f;
  endfunction

  // Reference model: header occupies 14 bytes (18 when tagged and VLAN support is built);
  // a shorter frame is a runt reported on its last byte, later bytes are payload.
  task automatic send_frame(input byte_q_t fr, input int gap_at, input int gap_len, input bit rnd_gaps);
    int          len = fr.size();
    int          hdr_len = 14;
    logic [47:0] dst = '0, src = '0;
    logic [15:0] et = '0;
    logic [11:0] vid = '0;
    exp_t        e;
    if (len >= 14) begin
      for (int k = 0; k < 6; k++) dst = {dst[39:0], fr[k]};
      for (int k = 6; k < 12; k++) src = {src[39:0], fr[k]};
      et = {fr[12], fr[13]};
`ifdef ETH_VLAN_EN
      if (et == 16'h8100) begin
        hdr_len = 18;
        if (len >= 18) begin
          vid = {fr[14][3:0], fr[15]};
          et  = {fr[16], fr[17]};
        end
      end
`endif
    end
    for (int i = 0; i < len; i++) begin
      int idle = (i == gap_at) ? gap_len : 0;
      if (rnd_gaps && $urandom_range(0, 3) == 0) idle += $urandom_range(1, 2);
      repeat (idle) begin
        @(negedge clk);
        in_datavalid = 1'b0;
        in_data      = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      in_datavalid = 1'b1;
      in_data      = fr[i];
      in_available = (i != len - 1);
      e = '{kind: EV_PAY, cyc: cyc + 1, dst: dst, src: src, etype: et, vid: vid,
            data: fr[i], first: (i == hdr_len), last: (i == len - 1)};
      if (len < hdr_len && i == len - 1) begin
        e.kind = EV_RUNT;
        sb.push_back(e);
        mdl_runts++;
      end else if (len >= hdr_len && i == hdr_len - 1) begin
        e.kind = EV_HDR;
        sb.push_back(e);
        mdl_frames++;
      end else if (i >= hdr_len) begin
        sb.push_back(e);
      end
    end
    @(negedge clk);
    in_datavalid = 1'b0;
    in_available = 1'b0;
    in_data      = '0;
  endtask

  task automatic drain_and_check(input string tag);
    #1;
    for (int k = 0; k < 10 && sb.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    check({tag, "_drained"}, 64'(sb.size()), 64'd0);
    check({tag, "_frame_count"}, 64'(frame_count), 64'(mdl_frames % (1 << CNT_W)));
    check({tag, "_runt_count"}, 64'(runt_count),
          64'((mdl_runts > (1 << ERR_W) - 1) ? (1 << ERR_W) - 1 : mdl_runts));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dst"}, 64'(dst_mac), 64'd0);
    check({tag, "_src"}, 64'(src_mac), 64'd0);
    check({tag, "_type"}, 64'(ethertype), 64'd0);
    check({tag, "_pulses"}, 64'({hdr_valid, pay_valid, pay_first, pay_last, runt_err}), 64'd0);
    check({tag, "_pay_data"}, 64'(pay_data), 64'd0);
    check({tag, "_counts"}, 64'({frame_count, runt_count}), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    byte_q_t fr;
    int      p0, h0, r0;
    rst_n        = 1'b0;
    in_available = 1'b0;
    in_datavalid = 1'b0;
    in_data      = '0;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 64-byte IPv4 frame: 50 payload bytes.
    p0 = n_pay; h0 = n_hdr;
    fr = make_frame(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800, 64);
    send_frame(fr, -1, 0, 1'b0);
    drain_and_check("f64");
    check("f64_pay_bytes", 64'(n_pay - p0), 64'd50);
    check("f64_hdr_pulses", 64'(n_hdr - h0), 64'd1);
    check("f64_dst_hold", 64'(dst_mac), 64'hFFFF_FFFF_FFFF);

    // 9-byte runt.
    p0 = n_pay; h0 = n_hdr; r0 = n_runt;
    fr = make_frame(48'h0A0B_0C0D_0E0F, 48'h1112_1314_1516, 16'h0800, 9);
    send_frame(fr, -1, 0, 1'b0);
    drain_and_check("runt9");
    check("runt9_activity", 64'({32'(n_pay - p0), 16'(n_hdr - h0), 16'(n_runt - r0)}), 64'd1);

    // Header-only ARP frame, then a frame right after to confirm return to IDLE.
    p0 = n_pay;
    fr = make_frame(48'h0102_0304_0506, 48'h0708_090A_0B0C, 16'h0806, 14);
    send_frame(fr, -1, 0, 1'b0);
    drain_and_check("hdr14");
    check("hdr14_pay_bytes", 64'(n_pay - p0), 64'd0);
    check("hdr14_type", 64'(ethertype), 64'h0806);

    // 64-byte frame paused for 3 cycles at byte 20.
    p0 = n_pay;
    fr = make_frame(48'h2222_3333_4444, 48'h5555_6666_7777, 16'h0800, 64);
    send_frame(fr, 20, 3, 1'b0);
    drain_and_check("pause");
    check("pause_pay_bytes", 64'(n_pay - p0), 64'd50);

    // Reset in the middle of a frame, then a clean 60-byte frame.
    fr = make_frame(48'hAAAA_BBBB_CCCC, 48'hDDDD_EEEE_FFFF, 16'h0800, 60);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_datavalid = 1'b1;
      in_available = 1'b1;
      in_data      = fr[i];
    end
    @(negedge clk);
    in_datavalid = 1'b0;
    rst_n        = 1'b0;
    #1;
    check_all_zero("midreset");
    mdl_frames = 0;
    mdl_runts  = 0;
    sb.delete();
    @(negedge clk);
    in_available = 1'b0;
    rst_n        = 1'b1;
    fr = make_frame(48'h1234_5678_9ABC, 48'hDEF0_1357_9BDF, 16'h0800, 60);
    send_frame(fr, -1, 0, 1'b0);
    drain_and_check("after_reset");
    check("after_reset_frames", 64'(frame_count), 64'd1);

`ifdef ETH_VLAN_EN
    fr = make_frame(48'h0000_0000_0001, 48'h0000_0000_0002, 16'h8100, 64);
    fr[14] = 8'h00; fr[15] = 8'h64; fr[16] = 8'h86; fr[17] = 8'hDD;
    p0 = n_pay;
    send_frame(fr, -1, 0, 1'b0);
    drain_and_check("vlan");
    check("vlan_id_100", 64'(vlan_id), 64'd100);
    check("vlan_inner_type", 64'(ethertype), 64'h86DD);
    check("vlan_pay_bytes", 64'(n_pay - p0), 64'd46);
`endif

    // Random frames: runts, header-only, tagged types and long frames with random pauses;
    // enough of each to wrap frame_count and saturate runt_count.
    for (int n = 0; n < 60; n++) begin
      int          len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 20) : $urandom_range(14, 80);
      logic [15:0] et  = ($urandom_range(0, 3) == 0) ? 16'h8100 : 16'($urandom_range(0, 65535));
      fr = make_frame({$urandom(), 16'($urandom())}, {$urandom(), 16'($urandom())}, et, len);
      send_frame(fr, -1, 0, 1'b1);
      drain_and_check("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
